// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 scan controller: prefix and
//               invalid byte codes, decoder state encoding and the key event
//               record carried through the event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;   // extended-key prefix
    localparam logic [7:0] PS2_BRK  = 8'hF0;   // key-release prefix
    localparam logic [7:0] PS2_ERR0 = 8'h00;   // keyboard error / overrun
    localparam logic [7:0] PS2_ERR1 = 8'hFF;   // keyboard error / overrun

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRE_E0   = 2'd1,
        ST_PRE_F0   = 2'd2,
        ST_PRE_E0F0 = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } key_event_t;

    localparam int KEY_EVENT_W = $bits(key_event_t);

    function automatic logic is_bad_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : DEPTH-entry FIFO of key events. A push while full is accepted
//               only when a pop happens in the same cycle. Head entry is read
//               straight from the storage flops, so it holds steady until popped.
// Ports       : clk, reset (async, active-low)
//               i_push / i_push_ev : write strobe and event
//               i_pop              : remove head (ignored when empty)
//               o_full, o_empty    : occupancy flags
//               o_head             : event at the head of the queue
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [KEY_EVENT_W-1:0] i_push_ev,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [KEY_EVENT_W-1:0] o_head
);

    localparam int              c_ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W:0] c_FULL_COUNT = (c_ADDR_W + 1)'(DEPTH);

    logic [KEY_EVENT_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_ADDR_W:0]      r_count;
    logic                   w_pop;
    logic                   w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_COUNT);
    assign w_pop   = i_pop & ~o_empty;
    // When full, the slot being freed by the pop is the one the write lands in.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_ev;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_controller
// Description : Brings PS/2 scan bytes into the system clock domain, folds the
//               E0 / F0 prefixes into single key events and queues them behind
//               a valid/ready interface. Flags invalid bytes, stalled prefixes
//               and prefix conflicts on err; flags dropped events on ovf.
// Options     : PS2_CTRL_REPEAT_FILTER_EN - suppress typematic repeats of the
//               key currently held down.
// Ports       : clk, reset (async, active-low)
//               byte_ready, byte_in : deserializer handoff (keyboard domain)
//               ev_valid, ev_ready  : event handshake
//               ev_code, ev_break, ev_ext : head event fields
//               err, ovf            : single-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_controller
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_ready,
    input  logic [7:0] byte_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       err,
    output logic       ovf
);

    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic               r_sync1, r_sync2, r_sync3;
    logic               w_take;
    ps2_state_t         r_state, w_next;
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_expire;
    logic               w_dec_push, w_dec_err, w_push;
    key_event_t         w_ev, w_head;
    logic               w_fifo_full, w_fifo_empty;

    // ------------------------------------------------------------------
    // Clock-domain crossing: two sync flops, the third keeps history so a
    // level held high produces a single take.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= byte_ready;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_take   = r_sync2 & ~r_sync3;
    // A take in the expiry cycle wins, so expiry is gated by ~w_take below.
    assign w_expire = (r_state != ST_IDLE) && (r_tmo == c_TMO_LAST);

    // ------------------------------------------------------------------
    // Prefix decode. byte_in is only looked at in the take cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_dec_push = 1'b0;
        w_dec_err  = 1'b0;
        w_ev.code  = byte_in;
        w_ev.brk   = 1'b0;
        w_ev.ext   = 1'b0;
        if (w_take) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (byte_in == PS2_EXT)      w_next = ST_PRE_E0;
                    else if (byte_in == PS2_BRK) w_next = ST_PRE_F0;
                    else if (is_bad_byte(byte_in)) w_dec_err = 1'b1;
                    else                         w_dec_push = 1'b1;
                end
                ST_PRE_E0: begin
                    if (byte_in == PS2_BRK) begin
                        w_next = ST_PRE_E0F0;
                    end else if (byte_in == PS2_EXT) begin
                        w_next = ST_PRE_E0;
                    end else begin
                        w_next     = ST_IDLE;
                        w_dec_err  = is_bad_byte(byte_in);
                        w_dec_push = ~is_bad_byte(byte_in);
                        w_ev.ext   = 1'b1;
                    end
                end
                ST_PRE_F0, ST_PRE_E0F0: begin
                    w_next = ST_IDLE;
                    if ((byte_in == PS2_EXT) || (byte_in == PS2_BRK) || is_bad_byte(byte_in)) begin
                        w_dec_err = 1'b1;
                    end else begin
                        w_dec_push = 1'b1;
                        w_ev.brk   = 1'b1;
                        w_ev.ext   = (r_state == ST_PRE_E0F0);
                    end
                end
            endcase
        end else if (w_expire) begin
            w_next    = ST_IDLE;
            w_dec_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            err     <= w_dec_err;
            if (w_take || w_expire || (r_state == ST_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

`ifdef PS2_CTRL_REPEAT_FILTER_EN
    // Remember the last make so auto-repeat of a held key is not queued.
    logic [7:0] r_trk_code;
    logic       r_trk_ext;
    logic       r_trk_held;
    logic       w_trk_match;

    assign w_trk_match = (w_ev.code == r_trk_code) && (w_ev.ext == r_trk_ext);
    assign w_push      = w_dec_push & ~(~w_ev.brk & r_trk_held & w_trk_match);

    // Tracking follows the decoded stream, independent of FIFO room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trk_code <= 8'h00;
            r_trk_ext  <= 1'b0;
            r_trk_held <= 1'b0;
        end else if (w_dec_push) begin
            if (!w_ev.brk) begin
                r_trk_code <= w_ev.code;
                r_trk_ext  <= w_ev.ext;
                r_trk_held <= 1'b1;
            end else if (w_trk_match) begin
                r_trk_held <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_dec_push;
`endif

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_push_ev (w_ev),
        .i_pop     (ev_ready),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_head)
    );

    assign ev_valid = ~w_fifo_empty;
    assign ev_code  = w_head.code;
    assign ev_break = w_head.brk;
    assign ev_ext   = w_head.ext;

    // Dropped only when full and the consumer is not freeing a slot this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= w_push & w_fifo_full & ~(ev_ready & ~w_fifo_empty);
        end
    end

endmodule
`default_nettype wire
